// File: rtl/valu_pkg.sv
// rtl/valu_pkg.sv - shared types, defaults and opcode legality for the vector ALU sequencer
// Contents:
//   ELEM_W_DEF / MAX_VL_DEF : default element width and maximum vector length
//   state_t                 : sequencer FSM states
//   alu_op_t                : ALU opcodes (ADD..SRA = 0..7); codes 8..15 are illegal
//   op_legal()              : returns 1 for a legal opcode
package valu_pkg;

  localparam int ELEM_W_DEF = 32;
  localparam int MAX_VL_DEF = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    EX   = 3'd2,
    WB   = 3'd3,
    DONE = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLL = 4'd5,
    OP_SRL = 4'd6,
    OP_SRA = 4'd7
  } alu_op_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= OP_SRA);
  endfunction

endpackage

// File: rtl/valu_sequencer_if.sv
// rtl/valu_sequencer_if.sv - instruction, register-file, ALU and status bundle of the sequencer
// Signals:
//   start_valid/start_ready       : instruction handshake
//   vd_addr, vs1_addr, vs2_addr   : vector register numbers
//   alu_op, vl, vm, v0_mask       : opcode, element count, mask enable (1 = unmasked), mask bits
//   rd_addr1/2, rd_elem, rd_data1/2 : synchronous register-file read (data one cycle after address)
//   alu_op1/2, alu_opcode, alu_res  : combinational ALU port
//   wr_en, wr_addr, wr_elem, wr_data: register-file element write
//   busy, done, err               : status; done is a one-cycle pulse, err is valid with done
// Modports: master = sequencer side, slave = environment (register file, ALU, requester).
import valu_pkg::*;

interface valu_sequencer_if #(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int MAX_VL = MAX_VL_DEF
);
  localparam int VL_W  = $clog2(MAX_VL + 1);
  localparam int IDX_W = $clog2(MAX_VL);

  logic              start_valid;
  logic              start_ready;
  logic [4:0]        vd_addr;
  logic [4:0]        vs1_addr;
  logic [4:0]        vs2_addr;
  logic [3:0]        alu_op;
  logic [VL_W-1:0]   vl;
  logic              vm;
  logic [MAX_VL-1:0] v0_mask;

  logic [4:0]        rd_addr1;
  logic [4:0]        rd_addr2;
  logic [IDX_W-1:0]  rd_elem;
  logic [ELEM_W-1:0] rd_data1;
  logic [ELEM_W-1:0] rd_data2;

  logic [ELEM_W-1:0] alu_op1;
  logic [ELEM_W-1:0] alu_op2;
  logic [3:0]        alu_opcode;
  logic [ELEM_W-1:0] alu_res;

  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [IDX_W-1:0]  wr_elem;
  logic [ELEM_W-1:0] wr_data;

  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start_valid, vd_addr, vs1_addr, vs2_addr, alu_op, vl, vm, v0_mask,
    input  rd_data1, rd_data2, alu_res,
    output start_ready, rd_addr1, rd_addr2, rd_elem,
    output alu_op1, alu_op2, alu_opcode,
    output wr_en, wr_addr, wr_elem, wr_data,
    output busy, done, err
  );

  modport slave (
    output start_valid, vd_addr, vs1_addr, vs2_addr, alu_op, vl, vm, v0_mask,
    output rd_data1, rd_data2, alu_res,
    input  start_ready, rd_addr1, rd_addr2, rd_elem,
    input  alu_op1, alu_op2, alu_opcode,
    input  wr_en, wr_addr, wr_elem, wr_data,
    input  busy, done, err
  );

endinterface

// File: rtl/valu_sequencer.sv
// rtl/valu_sequencer.sv - element-serial vector ALU sequencer (RD -> EX -> WB per element)
// Ports:
//   clk     : clock, all state on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : valu_sequencer_if.master (handshake, register-file read/write, ALU, status)
// Optional feature: define VALU_SEQ_MASK_EN to honour vm/v0_mask; masked-off elements still
// take their RD/EX/WB slots but do not write (mask-undisturbed). Without it every element
// below vl is written.
import valu_pkg::*;

module valu_sequencer #(
  parameter int ELEM_W = ELEM_W_DEF,
  parameter int MAX_VL = MAX_VL_DEF
) (
  input logic           clk,
  input logic           reset_n,
  valu_sequencer_if.master bus
);

  localparam int VL_W  = $clog2(MAX_VL + 1);
  localparam int IDX_W = $clog2(MAX_VL);

  state_t            state;
  state_t            state_nxt;

  logic [4:0]        vd_q;
  logic [4:0]        vs1_q;
  logic [4:0]        vs2_q;
  logic [3:0]        op_q;
  logic [VL_W-1:0]   vl_q;
  logic              vm_q;
  logic [MAX_VL-1:0] v0_q;
  logic              err_q;
  logic [IDX_W-1:0]  idx;
  logic [ELEM_W-1:0] res_q;

  logic              accept;
  logic              skip;
  logic              last_elem;
  logic              elem_active;
  logic [VL_W-1:0]   vl_clamped;

  assign accept     = bus.start_valid && (state == IDLE);
  assign vl_clamped = (bus.vl > VL_W'(MAX_VL)) ? VL_W'(MAX_VL) : bus.vl;
  // Empty or illegal instructions go straight to DONE without touching the register file.
  assign skip       = (bus.vl == '0) || !op_legal(bus.alu_op);
  // vl_q is never 0 while in WB, so vl_q-1 cannot underflow here.
  assign last_elem  = (VL_W'(idx) == (vl_q - VL_W'(1)));

`ifdef VALU_SEQ_MASK_EN
  assign elem_active = vm_q || v0_q[idx];
`else
  logic unused_mask;
  assign elem_active = 1'b1;
  assign unused_mask = ^{vm_q, v0_q};
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = skip ? DONE : RD;
        end
      end
      RD:      state_nxt = EX;
      EX:      state_nxt = WB;
      WB:      state_nxt = last_elem ? DONE : RD;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.start_ready = (state == IDLE);
    bus.busy        = (state != IDLE);
    bus.rd_addr1    = '0;
    bus.rd_addr2    = '0;
    bus.rd_elem     = '0;
    bus.alu_op1     = '0;
    bus.alu_op2     = '0;
    bus.alu_opcode  = '0;
    bus.wr_en       = 1'b0;
    bus.wr_addr     = '0;
    bus.wr_elem     = '0;
    bus.wr_data     = '0;
    bus.done        = 1'b0;
    bus.err         = 1'b0;
    case (state)
      RD: begin
        bus.rd_addr1 = vs1_q;
        bus.rd_addr2 = vs2_q;
        bus.rd_elem  = idx;
      end
      EX: begin
        bus.alu_op1    = bus.rd_data1;
        bus.alu_op2    = bus.rd_data2;
        bus.alu_opcode = op_q;
      end
      WB: begin
        bus.wr_en   = elem_active;
        bus.wr_addr = vd_q;
        bus.wr_elem = idx;
        bus.wr_data = res_q;
      end
      DONE: begin
        bus.done = 1'b1;
        bus.err  = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vd_q  <= '0;
      vs1_q <= '0;
      vs2_q <= '0;
      op_q  <= '0;
      vl_q  <= '0;
      vm_q  <= 1'b0;
      v0_q  <= '0;
      err_q <= 1'b0;
      idx   <= '0;
      res_q <= '0;
    end else begin
      if (accept) begin
        vd_q  <= bus.vd_addr;
        vs1_q <= bus.vs1_addr;
        vs2_q <= bus.vs2_addr;
        op_q  <= bus.alu_op;
        vl_q  <= vl_clamped;
        vm_q  <= bus.vm;
        v0_q  <= bus.v0_mask;
        err_q <= !op_legal(bus.alu_op);
        idx   <= '0;
      end
      if (state == EX) begin
        res_q <= bus.alu_res;
      end
      // Stepping stops on the last element, so idx never wraps past vl-1.
      if ((state == WB) && !last_elem) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_valu_sequencer.sv
// tb/tb_valu_sequencer.sv - self-checking bench for valu_sequencer (register file and ALU models)
module tb_valu_sequencer;

  localparam int EW = 32;
  localparam int MV = 16;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  vl;
    logic        vm;
    logic [15:0] mask;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    int          wr_mask;
    int          wr_nomask;
    int          lat;
    logic        err;
  } vec_t;

  typedef struct {
    int          edge_no;
    logic [4:0]  addr;
    logic [3:0]  elem;
    logic [31:0] data;
  } wr_exp_t;

  typedef struct {
    int   edge_no;
    logic err;
  } done_exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  int   accept_cnt = 0;
  int   done_cnt = 0;
  int   wr_cnt = 0;
  int   last_t = 0;
  int   prev_t = 0;
  int   cur_lat = 0;
  logic cur_err = 1'b0;

  logic [31:0] mem [32][16];
  wr_exp_t     sb_wr[$];
  done_exp_t   sb_done[$];
  vec_t        tbl[8];

  valu_sequencer_if #(.ELEM_W(EW), .MAX_VL(MV)) bus ();

  valu_sequencer #(.ELEM_W(EW), .MAX_VL(MV)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'h0;
    endcase
  endfunction

  // Parent-side ALU and register file.
  always_comb bus.alu_res = alu_model(bus.alu_opcode, bus.alu_op1, bus.alu_op2);

  always @(posedge clk) begin
    bus.rd_data1 <= mem[bus.rd_addr1][bus.rd_elem];
    bus.rd_data2 <= mem[bus.rd_addr2][bus.rd_elem];
    if (bus.wr_en) mem[bus.wr_addr][bus.wr_elem] <= bus.wr_data;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int exp_writes(input vec_t v);
`ifdef VALU_SEQ_MASK_EN
    return v.wr_mask;
`else
    return v.wr_nomask;
`endif
  endfunction

  // Scoreboard: expectations pushed at accept, popped as writes/done appear.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.start_valid && bus.start_ready) begin
        int t;
        int n;
        t = cyc + 1;
        prev_t = last_t;
        last_t = t;
        accept_cnt++;
        n = (bus.alu_op > 4'd7) ? 0 : ((bus.vl > 5'(MV)) ? MV : int'(bus.vl));
        for (int i = 0; i < n; i++) begin
          logic act;
`ifdef VALU_SEQ_MASK_EN
          act = bus.vm || bus.v0_mask[i];
`else
          act = 1'b1;
`endif
          if (act) begin
            wr_exp_t w;
            w.edge_no = t + 3 * (i + 1);
            w.addr    = bus.vd_addr;
            w.elem    = 4'(i);
            w.data    = alu_model(bus.alu_op, mem[bus.vs1_addr][i], mem[bus.vs2_addr][i]);
            sb_wr.push_back(w);
          end
        end
        sb_done.push_back('{t + cur_lat, cur_err});
      end
      if (bus.wr_en) begin
        wr_cnt++;
        if (sb_wr.size() == 0) begin
          chk("unexpected_write", {27'h0, bus.wr_addr, 4'h0, bus.wr_elem}, 64'hffff);
        end else begin
          wr_exp_t e;
          e = sb_wr.pop_front();
          chk("wr_edge", 64'(cyc + 1), 64'(e.edge_no));
          chk("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
          chk("wr_elem", 64'(bus.wr_elem), 64'(e.elem));
          chk("wr_data", 64'(bus.wr_data), 64'(e.data));
        end
      end
      if (bus.done) begin
        done_cnt++;
        if (sb_done.size() == 0) begin
          chk("unexpected_done", 64'(bus.done), 64'h0);
        end else begin
          done_exp_t d;
          d = sb_done.pop_front();
          chk("done_edge", 64'(cyc + 1), 64'(d.edge_no));
          chk("done_err", 64'(bus.err), 64'(d.err));
          chk("busy_at_done", 64'(bus.busy), 64'h1);
        end
      end else if (bus.err) begin
        chk("err_without_done", 64'(bus.err), 64'h0);
      end
    end
  end

  task automatic drive(input vec_t v);
    bus.alu_op      = v.op;
    bus.vl          = v.vl;
    bus.vm          = v.vm;
    bus.v0_mask     = v.mask;
    bus.vd_addr     = v.vd;
    bus.vs1_addr    = v.vs1;
    bus.vs2_addr    = v.vs2;
    bus.start_valid = 1'b1;
  endtask

  task automatic wait_accept(input int old);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (accept_cnt == old && n < 200);
    if (accept_cnt == old) chk("accept_timeout", 64'(accept_cnt), 64'(old + 1));
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (done_cnt < target && n < 300);
    if (done_cnt < target) chk("done_timeout", 64'(done_cnt), 64'(target));
  endtask

  task automatic run_vec(input vec_t v);
    int a0;
    int d0;
    int w0;
    a0 = accept_cnt;
    d0 = done_cnt;
    w0 = wr_cnt;
    cur_lat = v.lat;
    cur_err = v.err;
    @(posedge clk);
    #1 drive(v);
    wait_accept(a0);
    #1 bus.start_valid = 1'b0;
    wait_done(d0 + 1);
    #1;
    chk("ready_after_done", 64'(bus.start_ready), 64'h1);
    chk("idle_not_busy", 64'(bus.busy), 64'h0);
    chk("write_count", 64'(wr_cnt - w0), 64'(exp_writes(v)));
  endtask

  initial begin
    vec_t va;
    vec_t vb;
    vec_t vr;
    int   w0;
    int   a0;
    int   d0;
    int   n;

    for (int r = 0; r < 32; r++)
      for (int e = 0; e < 16; e++)
        mem[r][e] = $urandom;
    for (int e = 0; e < 16; e++) begin
      mem[1][e] = 32'(e + 1);
      mem[2][e] = 32'(10 * (e + 1));
    end

    //          op     vl     vm    mask      vd     vs1   vs2   msk nomsk lat err
    tbl[0] = '{4'd0, 5'd4,  1'b1, 16'h0000, 5'd10, 5'd1, 5'd2, 4,  4,  13, 1'b0};
    tbl[1] = '{4'd1, 5'd4,  1'b0, 16'h0005, 5'd11, 5'd2, 5'd1, 2,  4,  13, 1'b0};
    tbl[2] = '{4'd0, 5'd0,  1'b1, 16'h0000, 5'd12, 5'd1, 5'd2, 0,  0,  1,  1'b0};
    tbl[3] = '{4'd9, 5'd4,  1'b1, 16'h0000, 5'd12, 5'd1, 5'd2, 0,  0,  1,  1'b1};
    tbl[4] = '{4'd4, 5'd5,  1'b1, 16'h0000, 5'd12, 5'd3, 5'd4, 5,  5,  16, 1'b0};
    tbl[5] = '{4'd7, 5'd3,  1'b1, 16'h0000, 5'd13, 5'd3, 5'd4, 3,  3,  10, 1'b0};
    tbl[6] = '{4'd5, 5'd1,  1'b1, 16'h0000, 5'd13, 5'd4, 5'd3, 1,  1,  4,  1'b0};
    tbl[7] = '{4'd2, 5'd16, 1'b0, 16'hA5A5, 5'd14, 5'd3, 5'd4, 8,  16, 49, 1'b0};

    bus.start_valid = 1'b0;
    bus.alu_op = '0; bus.vl = '0; bus.vm = 1'b0; bus.v0_mask = '0;
    bus.vd_addr = '0; bus.vs1_addr = '0; bus.vs2_addr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1;
    chk("reset_ready", 64'(bus.start_ready), 64'h1);
    chk("reset_busy", 64'(bus.busy), 64'h0);
    chk("reset_done", 64'(bus.done), 64'h0);
    chk("reset_err", 64'(bus.err), 64'h0);
    chk("reset_wr_en", 64'(bus.wr_en), 64'h0);

    for (int i = 0; i < 8; i++) begin
      run_vec(tbl[i]);
      if (i == 0) begin
        chk("vadd_e0", 64'(mem[10][0]), 64'd11);
        chk("vadd_e1", 64'(mem[10][1]), 64'd22);
        chk("vadd_e2", 64'(mem[10][2]), 64'd33);
        chk("vadd_e3", 64'(mem[10][3]), 64'd44);
      end
    end

    // Reset in the middle of the WB slot of element 2.
    vr = '{4'd0, 5'd8, 1'b1, 16'h0000, 5'd20, 5'd3, 5'd4, 8, 8, 25, 1'b0};
    a0 = accept_cnt;
    cur_lat = vr.lat;
    cur_err = vr.err;
    @(posedge clk);
    #1 drive(vr);
    wait_accept(a0);
    #1 bus.start_valid = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!(bus.wr_en && bus.wr_elem == 4'd2) && n < 40);
    chk("wb2_reached", 64'(bus.wr_en && bus.wr_elem == 4'd2), 64'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_wr_en", 64'(bus.wr_en), 64'h0);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    sb_wr.delete();
    sb_done.delete();
    w0 = wr_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    #1 chk("rst_release_ready", 64'(bus.start_ready), 64'h1);
    repeat (10) @(posedge clk);
    chk("no_writes_after_reset", 64'(wr_cnt - w0), 64'h0);

    // Over-long vl held back-to-back with a second instruction.
    va = '{4'd3, 5'd21, 1'b1, 16'h0000, 5'd15, 5'd3, 5'd4, 16, 16, 49, 1'b0};
    vb = '{4'd6, 5'd2,  1'b1, 16'h0000, 5'd16, 5'd3, 5'd4, 2,  2,  7,  1'b0};
    a0 = accept_cnt;
    d0 = done_cnt;
    w0 = wr_cnt;
    cur_lat = va.lat;
    cur_err = va.err;
    @(posedge clk);
    #1 drive(va);
    wait_accept(a0);
    #1;
    cur_lat = vb.lat;
    cur_err = vb.err;
    drive(vb);
    wait_accept(a0 + 1);
    #1 bus.start_valid = 1'b0;
    chk("b2b_gap", 64'(last_t - prev_t), 64'd50);
    wait_done(d0 + 2);
    #1;
    chk("b2b_ready", 64'(bus.start_ready), 64'h1);
    chk("b2b_writes", 64'(wr_cnt - w0), 64'd18);

    repeat (3) @(posedge clk);
    chk("sb_wr_empty", 64'(sb_wr.size()), 64'h0);
    chk("sb_done_empty", 64'(sb_done.size()), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/valu_sequencer.md
VALU_SEQUENCER -- requirements
Module: valu_sequencer

Interface
REQ-001 Parameter ELEM_W, default 32, SHALL set the element/ALU operand width in bits.
REQ-002 Parameter MAX_VL, default 16, SHALL set the maximum elements per instruction; VL_W = $clog2(MAX_VL+1), IDX_W = $clog2(MAX_VL).
REQ-003 One clock and an asynchronous active-low reset SHALL be used: clk input 1 (all state on rising edge); reset_n input 1 (asynchronous, active-low).
REQ-004 start_valid input 1: instruction offered; start_ready output 1: sequencer can accept.
REQ-005 vd_addr, vs1_addr, vs2_addr inputs 5 each: destination and source vector register numbers.
REQ-006 alu_op input 4: ALU operation code; vl input VL_W: element count; vm input 1: 1 = unmasked, 0 = masked by v0.
REQ-007 v0_mask input MAX_VL: mask bits, bit i governs element i, sampled at accept.
REQ-008 rd_addr1, rd_addr2 outputs 5; rd_elem output IDX_W; rd_data1, rd_data2 inputs ELEM_W: synchronous register-file read, data valid the cycle after address.
REQ-009 alu_op1, alu_op2 outputs ELEM_W; alu_opcode output 4; alu_res input ELEM_W: combinational ALU port.
REQ-010 wr_en output 1, wr_addr output 5, wr_elem output IDX_W, wr_data output ELEM_W: register-file element write port.
REQ-011 busy output 1; done output 1 (single-cycle pulse); err output 1 (valid with done).

Function
REQ-012 FSM states SHALL be IDLE, RD, EX, WB, DONE; start_ready = (state == IDLE).
REQ-013 Accept occurs on start_valid && start_ready; all instruction fields, vl and v0_mask SHALL be latched and held stable until DONE.
REQ-014 Accept with vl==0 SHALL go IDLE->DONE, no writes; vl > MAX_VL SHALL be clamped to MAX_VL.
REQ-015 alu_op > 4'b0111 SHALL be flagged illegal: IDLE->DONE, no writes, err=1 with done.
REQ-016 RD: drive rd_addr1=vs1, rd_addr2=vs2, rd_elem=idx; next state EX.
REQ-017 EX: alu_op1=rd_data1, alu_op2=rd_data2, alu_opcode=latched op; alu_res SHALL be registered; next state WB.
REQ-018 WB: wr_addr=vd, wr_elem=idx, wr_data=registered result; wr_en=1 only if element active (REQ-024); then idx+1, or DONE if idx==vl-1.
REQ-019 Timing: accept at cycle T, element i write at T+3(i+1), done=1 at T+3*vl+1, start_ready=1 at T+3*vl+2.
REQ-020 DONE: done=1 for exactly one cycle, then IDLE; busy=1 in every state except IDLE.
REQ-021 start_valid while not ready SHALL be ignored (no queueing); the requester holds it.
REQ-022 Element index SHALL never wrap: idx resets to 0 at accept; outputs with no owning state drive 0.

Reset
REQ-023 reset_n low SHALL force, asynchronously, state=IDLE, idx=0, all latched fields=0, wr_en=0, done=0, err=0, busy=0, start_ready=1 after release; reset mid-instruction abandons it with no further writes.

Configuration
REQ-024 Macro VALU_SEQ_MASK_EN defined: element i active iff vm==1 or latched v0_mask[i]==1; inactive elements get wr_en=0 but still consume RD/EX/WB cycles (mask-undisturbed).
REQ-025 VALU_SEQ_MASK_EN undefined: vm and v0_mask ignored, every element below vl written; timing unchanged.

Structure
REQ-026 Package valu_pkg SHALL hold the FSM state enum, the ALU opcode enum (ADD=0..SRA=7), ELEM_W/MAX_VL defaults and the opcode-legality function.
REQ-027 No sub-module: FSM, counter and result register in one module; the ALU is instantiated by the parent.

Verification
REQ-028 vadd, vl=4, vm=1, vs1 elems {1,2,3,4}, vs2 {10,20,30,40} -> writes {11,22,33,44} at T+3,6,9,12; done at T+13.
REQ-029 vsub, vl=4, vm=0, v0_mask=4'b0101, MASK_EN defined -> wr_en only for elems 0,2; undefined -> all four written.
REQ-030 vl=0 -> no wr_en, done at T+1, start_ready at T+2; alu_op=4'b1001 -> no wr_en, done and err=1 at T+1.
REQ-031 reset_n low during WB of elem 2, vl=8 -> wr_en=0 immediately, busy=0, no later writes, next start accepted normally.
REQ-032 vl=MAX_VL+5 -> exactly MAX_VL writes, wr_elem 0..MAX_VL-1, no wrap; back-to-back start_valid held high -> second instruction accepted at T+3*vl+2.
